// File: rtl/hub75_panel_init.sv
// rtl/hub75_panel_init.sv - power-on configuration loader for FM6126A-style HUB75 driver chips
// Shifts each register across the panel width with latch-length encoding, then hands the pins back.
module hub75_panel_init #(
  parameter int                     PANEL_WIDTH  = 64,
  parameter int                     NUM_REGS     = 2,
  parameter logic [NUM_REGS*16-1:0] REG_VALUES   = {16'h0040, 16'h7FFF},
  parameter logic [NUM_REGS*8-1:0]  LATCH_CLOCKS = {8'd13, 8'd12},
  parameter int                     CHAINS       = 2,
  parameter int                     CLK_DIV      = 1,
  parameter bit                     AUTO_START   = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  start_in,
  output logic [3*CHAINS-1:0]   rgb_out,
  output logic                  latch_out,
  output logic                  pixclock_out,
  output logic                  oe_mask_out,
  output logic                  busy,
  output logic                  done_pulse
);

  localparam int CW = $clog2(PANEL_WIDTH + 1);
  localparam int RW = $clog2(NUM_REGS + 1);
  localparam int DW = $clog2(2 * CLK_DIV + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(PANEL_WIDTH - 1);
  localparam logic [RW-1:0] REG_LAST = RW'(NUM_REGS - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST = DW'(2 * CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, REG_GAP, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   col, col_n;
  logic [RW-1:0]   reg_idx, reg_n;
  logic [DW-1:0]   div, div_n;
  logic            auto_pending, auto_n;
  logic [15:0]     word;
  int              latch_len;
  logic            shifting, data_bit;
  logic [3*CHAINS-1:0] rgb_n;
  logic            latch_n, pix_n, busy_n, done_n;

  always_comb begin
    state_n = state;
    col_n   = col;
    reg_n   = reg_idx;
    div_n   = div;
    auto_n  = auto_pending;
    case (state)
      IDLE: begin
        if (start_in || auto_pending) begin
          state_n = SHIFT_LO;
          col_n   = '0;
          reg_n   = '0;
          div_n   = '0;
          auto_n  = 1'b0;
        end
      end
      SHIFT_LO: begin
        if (div == HALF_LAST) begin
          div_n   = '0;
          state_n = SHIFT_HI;
        end else begin
          div_n = div + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div == HALF_LAST) begin
          div_n = '0;
          if (col != COL_LAST) begin
            col_n   = col + 1'b1;
            state_n = SHIFT_LO;
          end else begin
            col_n   = '0;
            state_n = REG_GAP;
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      REG_GAP: begin
        if (div == GAP_LAST) begin
          div_n = '0;
          if (reg_idx != REG_LAST) begin
            reg_n   = reg_idx + 1'b1;
            state_n = SHIFT_LO;
          end else begin
            state_n = DONE;
          end
        end else begin
          div_n = div + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are derived from the next state so that every pin comes straight off a flop.
    word      = 16'(REG_VALUES >> (16 * int'(reg_n)));
    latch_len = int'(8'(LATCH_CLOCKS >> (8 * int'(reg_n))));
    if (latch_len > PANEL_WIDTH) latch_len = PANEL_WIDTH;
    shifting  = (state_n == SHIFT_LO) || (state_n == SHIFT_HI);
    data_bit  = shifting && word[4'(int'(col_n) % 16)];
    rgb_n     = {(3 * CHAINS){data_bit}};
    latch_n   = shifting && (int'(col_n) >= PANEL_WIDTH - latch_len);
    pix_n     = (state_n == SHIFT_HI);
    busy_n    = shifting || (state_n == REG_GAP);
    done_n    = (state_n == DONE);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= IDLE;
      col          <= '0;
      reg_idx      <= '0;
      div          <= '0;
      auto_pending <= AUTO_START;
      rgb_out      <= '0;
      latch_out    <= 1'b0;
      pixclock_out <= 1'b0;
      oe_mask_out  <= 1'b1;
      busy         <= 1'b0;
      done_pulse   <= 1'b0;
    end else begin
      state        <= state_n;
      col          <= col_n;
      reg_idx      <= reg_n;
      div          <= div_n;
      auto_pending <= auto_n;
      rgb_out      <= rgb_n;
      latch_out    <= latch_n;
      pixclock_out <= pix_n;
      oe_mask_out  <= ~busy_n;
      busy         <= busy_n;
      done_pulse   <= done_n;
    end
  end

endmodule

// File: tb/tb_hub75_panel_init.sv
// tb/tb_hub75_panel_init.sv - directed bench for hub75_panel_init
// Instance a: default 64x2 auto-start; instance b: 20 columns, 3 regs, 4 chains, CLK_DIV=3, manual start.
module tb_hub75_panel_init;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, start_a = 1'b0;
  logic [5:0]  rgb_a;
  logic        lat_a, pix_a, oe_a, busy_a, done_a;

  logic        rst_b = 1'b1, start_b = 1'b0;
  logic [11:0] rgb_b;
  logic        lat_b, pix_b, oe_b, busy_b, done_b;

  hub75_panel_init dut_a (
    .clk_in(clk), .reset(rst_a), .start_in(start_a), .rgb_out(rgb_a), .latch_out(lat_a),
    .pixclock_out(pix_a), .oe_mask_out(oe_a), .busy(busy_a), .done_pulse(done_a)
  );

  hub75_panel_init #(
    .PANEL_WIDTH(20), .NUM_REGS(3),
    .REG_VALUES({16'hA5A5, 16'h0001, 16'hFFFE}),
    .LATCH_CLOCKS({8'd5, 8'd0, 8'd70}),
    .CHAINS(4), .CLK_DIV(3), .AUTO_START(1'b0)
  ) dut_b (
    .clk_in(clk), .reset(rst_b), .start_in(start_b), .rgb_out(rgb_b), .latch_out(lat_b),
    .pixclock_out(pix_b), .oe_mask_out(oe_b), .busy(busy_b), .done_pulse(done_b)
  );

  logic sel = 1'b0;
  logic o_pix, o_lat, o_done, o_oe, o_busy, o_bit, o_uni;
  always_comb begin
    if (sel) begin
      o_pix = pix_b; o_lat = lat_b; o_done = done_b; o_oe = oe_b; o_busy = busy_b;
      o_bit = rgb_b[0]; o_uni = (rgb_b == '0) || (rgb_b == '1);
    end else begin
      o_pix = pix_a; o_lat = lat_a; o_done = done_a; o_oe = oe_a; o_busy = busy_a;
      o_bit = rgb_a[0]; o_uni = (rgb_a == '0) || (rgb_a == '1);
    end
  end

  int passed = 0, total = 0;
  int rises, done_cycle, done_count, oe_low, glitch, hi_bad, nonuni, first_rise;
  logic [127:0] rgb_cap, lat_cap;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Samples cycles 1..ncyc of the selected instance; start is driven high for the cycles named.
  task automatic capture(input int ncyc, input int hi_len, input int st1, input int st2);
    logic prev_pix = 1'b0, prev_bit = 1'b0, prev_lat = 1'b0;
    int run = 0;
    rises = 0; done_cycle = -1; done_count = 0; oe_low = 0; glitch = 0;
    hi_bad = 0; nonuni = 0; first_rise = -1; rgb_cap = '0; lat_cap = '0;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk); #1;
      if (o_pix && !prev_pix) begin
        if (rises < 128) begin
          rgb_cap[7'(rises)] = o_bit;
          lat_cap[7'(rises)] = o_lat;
        end
        if (first_rise < 0) first_rise = n;
        rises++;
      end
      if (o_pix) run++;
      else begin
        if (prev_pix && run != hi_len) hi_bad++;
        run = 0;
      end
      if (o_pix && (o_bit != prev_bit || o_lat != prev_lat)) glitch++;
      if (!o_uni) nonuni++;
      if (o_done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = n;
      end
      if (!o_oe) oe_low++;
      prev_pix = o_pix; prev_bit = o_bit; prev_lat = o_lat;
      if (sel) start_b = (n == st1) || (n == st2);
      else     start_a = (n == st1) || (n == st2);
    end
  endtask

  localparam logic [127:0] A_RGB = {{4{16'h0040}}, {4{16'h7FFF}}};
  localparam logic [127:0] A_LAT = {64'hFFF8_0000_0000_0000, 64'hFFF0_0000_0000_0000};
  localparam logic [127:0] B_RGB = {68'h0, 20'h5A5A5, 20'h10001, 20'hEFFFE};
  localparam logic [127:0] B_LAT = {68'h0, 20'hF8000, 20'h00000, 20'hFFFFF};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_rgb", 128'(rgb_a), 0);
    check("a_reset_latch", 128'(lat_a), 0);
    check("a_reset_pix", 128'(pix_a), 0);
    check("a_reset_oe", 128'(oe_a), 1);
    check("a_reset_busy", 128'(busy_a), 0);
    check("a_reset_done", 128'(done_a), 0);

    sel = 1'b0;
    rst_a = 1'b0;
    capture(270, 1, 0, 0);
    check("a_rises", rises, 128);
    check("a_first_rise", first_rise, 2);
    check("a_done_cycle", done_cycle, 261);
    check("a_done_count", done_count, 1);
    check("a_oe_low", oe_low, 260);
    check("a_rgb", rgb_cap, A_RGB);
    check("a_latch", lat_cap, A_LAT);
    check("a_glitch", glitch, 0);
    check("a_hi_len", hi_bad, 0);
    check("a_uniform", nonuni, 0);
    check("a_idle_busy", 128'(busy_a), 0);

    // Re-trigger the auto run, then abort it during column 20 of register 1.
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    capture(172, 1, 0, 0);
    check("a_abort_rises", rises, 85);
    check("a_abort_pix_before", 128'(pix_a), 1);
    rst_a = 1'b1;
    @(posedge clk); #1;
    check("a_abort_pix", 128'(pix_a), 0);
    check("a_abort_oe", 128'(oe_a), 1);
    check("a_abort_busy", 128'(busy_a), 0);
    check("a_abort_rgb", 128'(rgb_a), 0);
    check("a_abort_latch", 128'(lat_a), 0);
    rst_a = 1'b0;
    capture(270, 1, 0, 0);
    check("a_rerun_rises", rises, 128);
    check("a_rerun_done", done_cycle, 261);
    check("a_rerun_rgb", rgb_cap, A_RGB);
    check("a_rerun_latch", lat_cap, A_LAT);

    sel = 1'b1;
    rst_b = 1'b0;
    capture(20, 3, 0, 0);
    check("b_idle_rises", rises, 0);
    check("b_idle_oe", oe_low, 0);
    check("b_idle_done", done_count, 0);

    // Start at cycle 0; extra starts mid-run (100) and in the DONE cycle (379) must be ignored.
    start_b = 1'b1;
    capture(420, 3, 100, 379);
    check("b_rises", rises, 60);
    check("b_first_rise", first_rise, 4);
    check("b_done_cycle", done_cycle, 379);
    check("b_done_count", done_count, 1);
    check("b_oe_low", oe_low, 378);
    check("b_rgb", rgb_cap, B_RGB);
    check("b_latch", lat_cap, B_LAT);
    check("b_glitch", glitch, 0);
    check("b_hi_len", hi_bad, 0);
    check("b_uniform", nonuni, 0);

    start_b = 1'b1;
    capture(400, 3, 0, 0);
    check("b_run2_rises", rises, 60);
    check("b_run2_done", done_cycle, 379);
    check("b_run2_rgb", rgb_cap, B_RGB);
    check("b_run2_latch", lat_cap, B_LAT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
